// File: rtl/multi_warp_simd_core.sv
// Multi-warp SIMD core: resident warp slots, serial register init, round-robin
// issue of LEGv8 R-format ALU ops. Optional counters behind SIMD_PERF_CNT_EN.
module multi_warp_simd_core #(
    parameter int THREAD_COUNT = 4,
    parameter int NUM_WARPS    = 4,
    parameter int DATA_W       = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           kernel_valid,
    output logic                           kernel_ready,
    input  logic [40:0]                    kernel_in,
    output logic                           init_req_valid,
    output logic [4:0]                     init_reg_idx,
    output logic [3:0]                     init_warp_id,
    input  logic [DATA_W*THREAD_COUNT-1:0] init_reg_data,
    output logic                           imem_req_valid,
    output logic [31:0]                    imem_req_pc,
    input  logic                           imem_rsp_valid,
    input  logic [31:0]                    imem_rsp_instr,
    output logic                           done_valid,
    output logic [3:0]                     done_warp_id,
    output logic [DATA_W*THREAD_COUNT-1:0] result_out
`ifdef SIMD_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stall
`endif
);
    localparam int SW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int LW = DATA_W * THREAD_COUNT;
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_EOR = 11'b11001010000;

    typedef enum logic [1:0] {SLOT_FREE, SLOT_INIT, SLOT_READY, SLOT_RUN} slot_t;
    typedef enum logic [1:0] {CORE_IDLE, CORE_FETCH, CORE_EXEC} core_t;

    slot_t             r_slot_state [NUM_WARPS];
    logic [3:0]        r_warp_id    [NUM_WARPS];
    logic [4:0]        r_tc         [NUM_WARPS];
    logic [31:0]       r_pc         [NUM_WARPS];
    logic [DATA_W-1:0] r_last       [NUM_WARPS][THREAD_COUNT];
    core_t             r_core_state;
    logic [SW-1:0]     r_cur_slot, r_last_issued, r_init_slot;
    logic              r_init_busy;
    logic [4:0]        r_init_idx;
    logic [31:0]       r_instr;
    logic              r_imem_req_valid, r_done_valid;
    logic [31:0]       r_imem_req_pc;
    logic [3:0]        r_done_warp_id;
    logic [LW-1:0]     r_result;

    logic              w_free_found, w_init_found, w_ready_found, w_init_valid;
    logic [SW-1:0]     w_free_slot, w_init_low, w_ready_slot, w_init_slot;
    logic [4:0]        w_tc_in, w_tc_eff, w_rn, w_rm, w_rd;
    logic [10:0]       w_opcode;
    logic              w_op_valid, w_exec_wr;
    logic [THREAD_COUNT-1:0] w_act_init, w_act_exec;
    logic [LW-1:0]     w_alu_flat;

    // Lowest-index FREE/INIT slots; READY search starts just after the last issued slot.
    always_comb begin
        int idx;
        idx          = 0;
        w_free_found = 1'b0;
        w_free_slot  = '0;
        w_init_found = 1'b0;
        w_init_low   = '0;
        w_ready_found = 1'b0;
        w_ready_slot  = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (r_slot_state[i] == SLOT_FREE) begin
                w_free_found = 1'b1;
                w_free_slot  = SW'(i);
            end
            if (r_slot_state[i] == SLOT_INIT) begin
                w_init_found = 1'b1;
                w_init_low   = SW'(i);
            end
        end
        for (int k = NUM_WARPS; k >= 1; k--) begin
            idx = (int'(r_last_issued) + k) % NUM_WARPS;
            if (r_slot_state[idx] == SLOT_READY) begin
                w_ready_found = 1'b1;
                w_ready_slot  = SW'(idx);
            end
        end
    end

    // Init slot is locked once started so a newly accepted lower slot cannot cut in.
    assign w_init_slot    = r_init_busy ? r_init_slot : w_init_low;
    assign w_init_valid   = r_init_busy | w_init_found;
    assign init_req_valid = w_init_valid;
    assign init_reg_idx   = r_init_idx;
    assign init_warp_id   = w_init_valid ? r_warp_id[w_init_slot] : 4'd0;
    assign kernel_ready   = w_free_found;

    assign w_tc_in  = kernel_in[36:32];
    assign w_tc_eff = (w_tc_in == 5'd0) ? 5'd1 :
                      (w_tc_in > 5'(THREAD_COUNT)) ? 5'(THREAD_COUNT) : w_tc_in;

    assign w_opcode   = r_instr[31:21];
    assign w_rm       = r_instr[20:16];
    assign w_rn       = r_instr[9:5];
    assign w_rd       = r_instr[4:0];
    assign w_op_valid = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) || (w_opcode == OP_AND) ||
                        (w_opcode == OP_ORR) || (w_opcode == OP_EOR);
    assign w_exec_wr  = (r_core_state == CORE_EXEC) && w_op_valid && (w_rd != 5'd31);

    genvar gi;
    generate
        for (gi = 0; gi < THREAD_COUNT; gi++) begin : g_lane
            logic [DATA_W-1:0] r_rf [1 << (SW + 5)];
            logic [DATA_W-1:0] r_rn_q, r_rm_q;
            logic [DATA_W-1:0] w_a, w_b, w_res;

            assign w_act_init[gi] = (5'(gi) < r_tc[w_init_slot]);
            assign w_act_exec[gi] = (5'(gi) < r_tc[r_cur_slot]);

            // Operands are read as the instruction arrives so EXEC sees registered data.
            always_ff @(posedge clk) begin
                if (w_init_valid && w_act_init[gi])
                    r_rf[{w_init_slot, r_init_idx}] <= init_reg_data[gi*DATA_W +: DATA_W];
                if (w_exec_wr && w_act_exec[gi])
                    r_rf[{r_cur_slot, w_rd}] <= w_res;
                if (r_core_state == CORE_FETCH && imem_rsp_valid) begin
                    r_rn_q <= r_rf[{r_cur_slot, imem_rsp_instr[9:5]}];
                    r_rm_q <= r_rf[{r_cur_slot, imem_rsp_instr[20:16]}];
                end
            end

            always_comb begin
                w_a = (w_rn == 5'd31) ? '0 : r_rn_q;
                w_b = (w_rm == 5'd31) ? '0 : r_rm_q;
                case (w_opcode)
                    OP_ADD:  w_res = w_a + w_b;
                    OP_SUB:  w_res = w_a - w_b;
                    OP_AND:  w_res = w_a & w_b;
                    OP_ORR:  w_res = w_a | w_b;
                    OP_EOR:  w_res = w_a ^ w_b;
                    default: w_res = '0;
                endcase
            end
            assign w_alu_flat[gi*DATA_W +: DATA_W] = w_res;
        end
    endgenerate

    // Each branch touches a slot in a distinct state, so per-slot updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_WARPS; s++) begin
                r_slot_state[s] <= SLOT_FREE;
                r_warp_id[s]    <= '0;
                r_tc[s]         <= 5'd1;
                r_pc[s]         <= '0;
                for (int t = 0; t < THREAD_COUNT; t++) r_last[s][t] <= '0;
            end
            r_core_state     <= CORE_IDLE;
            r_cur_slot       <= '0;
            r_last_issued    <= '0;
            r_init_slot      <= '0;
            r_init_busy      <= 1'b0;
            r_init_idx       <= '0;
            r_instr          <= '0;
            r_imem_req_valid <= 1'b0;
            r_imem_req_pc    <= '0;
            r_done_valid     <= 1'b0;
            r_done_warp_id   <= '0;
            r_result         <= '0;
        end else begin
            if (kernel_valid && w_free_found) begin
                r_slot_state[w_free_slot] <= SLOT_INIT;
                r_warp_id[w_free_slot]    <= kernel_in[40:37];
                r_tc[w_free_slot]         <= w_tc_eff;
                r_pc[w_free_slot]         <= kernel_in[31:0];
                for (int t = 0; t < THREAD_COUNT; t++) r_last[w_free_slot][t] <= '0;
            end
            if (w_init_valid) begin
                r_init_idx <= r_init_idx + 5'd1;
                if (r_init_idx == 5'd31) begin
                    r_init_busy               <= 1'b0;
                    r_slot_state[w_init_slot] <= SLOT_READY;
                end else begin
                    r_init_busy <= 1'b1;
                    r_init_slot <= w_init_slot;
                end
            end
            case (r_core_state)
                CORE_IDLE: if (w_ready_found) begin
                    r_slot_state[w_ready_slot] <= SLOT_RUN;
                    r_cur_slot       <= w_ready_slot;
                    r_last_issued    <= w_ready_slot;
                    r_imem_req_valid <= 1'b1;
                    r_imem_req_pc    <= r_pc[w_ready_slot];
                    r_core_state     <= CORE_FETCH;
                end
                CORE_FETCH: if (imem_rsp_valid) begin
                    r_imem_req_valid <= 1'b0;
                    r_imem_req_pc    <= '0;
                    r_instr          <= imem_rsp_instr;
                    r_core_state     <= CORE_EXEC;
                    if (imem_rsp_instr == 32'd0) begin
                        r_done_valid   <= 1'b1;
                        r_done_warp_id <= r_warp_id[r_cur_slot];
                        for (int t = 0; t < THREAD_COUNT; t++)
                            r_result[t*DATA_W +: DATA_W] <= r_last[r_cur_slot][t];
                    end
                end
                default: begin
                    r_core_state   <= CORE_IDLE;
                    r_done_valid   <= 1'b0;
                    r_done_warp_id <= '0;
                    r_result       <= '0;
                    if (r_instr == 32'd0) begin
                        r_slot_state[r_cur_slot] <= SLOT_FREE;
                    end else begin
                        r_slot_state[r_cur_slot] <= SLOT_READY;
                        r_pc[r_cur_slot]         <= r_pc[r_cur_slot] + 32'd4;
                    end
                    for (int t = 0; t < THREAD_COUNT; t++)
                        if (w_exec_wr && w_act_exec[t])
                            r_last[r_cur_slot][t] <= w_alu_flat[t*DATA_W +: DATA_W];
                end
            endcase
        end
    end

    assign imem_req_valid = r_imem_req_valid;
    assign imem_req_pc    = r_imem_req_pc;
    assign done_valid     = r_done_valid;
    assign done_warp_id   = r_done_warp_id;
    assign result_out     = r_result;

`ifdef SIMD_PERF_CNT_EN
    logic [31:0] r_perf_issued, r_perf_stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_core_state == CORE_EXEC && r_perf_issued != 32'hFFFF_FFFF)
                r_perf_issued <= r_perf_issued + 32'd1;
            if (r_core_state == CORE_FETCH && !imem_rsp_valid && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_multi_warp_simd_core.sv
// Self-checking bench for multi_warp_simd_core: directed scenarios plus random
// kernels checked against a per-warp behavioural register/ALU model.
module tb_multi_warp_simd_core;
    localparam int TC = 4;
    localparam int NW = 4;
    localparam int DW = 32;
    localparam int LW = TC * DW;
    localparam int MULT [4] = '{1, 2, 3, 5};
    localparam logic [10:0] OPS [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                                        11'b10101010000, 11'b11001010000, 11'b11111111111};

    logic clk = 1'b0;
    logic rst_n;
    logic kernel_valid, kernel_ready;
    logic [40:0] kernel_in;
    logic init_req_valid;
    logic [4:0] init_reg_idx;
    logic [3:0] init_warp_id;
    logic [LW-1:0] init_reg_data;
    logic imem_req_valid, imem_rsp_valid;
    logic [31:0] imem_req_pc, imem_rsp_instr;
    logic done_valid;
    logic [3:0] done_warp_id;
    logic [LW-1:0] result_out;

    int n_cmp = 0, n_err = 0, n_done = 0;
    logic [LW-1:0] init_tab [16][32];
    logic [31:0]   prog [int unsigned];
    logic [DW-1:0] m_rf [16][32][TC];
    logic [DW-1:0] m_last [16][TC];
    int            m_tc [16];
    int            exp_done [$];
    int            fetch_log [$];
    bit            rsp_en = 1'b0;
    int            min_dly = 0, max_dly = 0;

    multi_warp_simd_core #(.THREAD_COUNT(TC), .NUM_WARPS(NW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .kernel_valid(kernel_valid), .kernel_ready(kernel_ready), .kernel_in(kernel_in),
        .init_req_valid(init_req_valid), .init_reg_idx(init_reg_idx),
        .init_warp_id(init_warp_id), .init_reg_data(init_reg_data),
        .imem_req_valid(imem_req_valid), .imem_req_pc(imem_req_pc),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
        .done_valid(done_valid), .done_warp_id(done_warp_id), .result_out(result_out)
    );

    always #5 clk = ~clk;

    assign init_reg_data = init_tab[init_warp_id][init_reg_idx];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [10:0] op;
        op = OPS[$urandom_range(0, 5)];
        return {op, 5'($urandom_range(0, 31)), 6'($urandom), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31))};
    endfunction

    // Warp-level semantics: each active lane applies the operation to its own registers.
    function automatic void model_exec(int w, logic [31:0] ins);
        logic [10:0] op;
        int rm, rn, rd;
        logic [DW-1:0] a, b, r;
        bit wr;
        if (ins == 32'd0) begin
            exp_done.push_back(w);
            return;
        end
        op = ins[31:21];
        rm = int'(ins[20:16]);
        rn = int'(ins[9:5]);
        rd = int'(ins[4:0]);
        for (int t = 0; t < m_tc[w]; t++) begin
            a  = (rn == 31) ? '0 : m_rf[w][rn][t];
            b  = (rm == 31) ? '0 : m_rf[w][rm][t];
            wr = 1'b1;
            r  = '0;
            case (op)
                11'b10001011000: r = a + b;
                11'b11001011000: r = a - b;
                11'b10001010000: r = a & b;
                11'b10101010000: r = a | b;
                11'b11001010000: r = a ^ b;
                default:         wr = 1'b0;
            endcase
            if (wr && rd != 31) begin
                m_rf[w][rd][t] = r;
                m_last[w][t]   = r;
            end
        end
    endfunction

    function automatic logic [LW-1:0] m_result(int w);
        logic [LW-1:0] res;
        res = '0;
        for (int t = 0; t < TC; t++) res[t*DW +: DW] = m_last[w][t];
        return res;
    endfunction

    task automatic setup_kernel(input int w, input int len, input bit formula);
        int unsigned base;
        base = 32'h1000 * w;
        for (int r = 0; r < 32; r++)
            for (int t = 0; t < TC; t++)
                init_tab[w][r][t*DW +: DW] = formula ? DW'(r * MULT[t]) : DW'($urandom);
        for (int i = 0; i < len; i++) prog[base + 4*i] = rand_instr();
        prog[base + 4*len] = 32'd0;
    endtask

    task automatic submit(input int w, input int tc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!kernel_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("submit_ready", kernel_ready, 1);
        m_tc[w] = (tc == 0) ? 1 : tc;
        for (int t = 0; t < TC; t++) begin
            m_last[w][t] = '0;
            for (int r = 0; r < 32; r++) m_rf[w][r][t] = init_tab[w][r][t*DW +: DW];
        end
        kernel_valid = 1'b1;
        kernel_in    = {4'(w), 5'(tc), 32'(w * 32'h1000)};
        @(posedge clk);
        #1 kernel_valid = 1'b0;
        $display("submit warp %0d thread_count %0d start_pc %h", w, tc, w * 32'h1000);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int g;
        g = 0;
        while (n_done < target && g < budget) begin
            @(negedge clk);
            g++;
        end
        check_eq("done_count", n_done, target);
    endtask

    // Instruction memory with a configurable response latency.
    initial begin : imem_resp
        int wcnt, dly, w;
        bit busy;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        busy = 1'b0;
        wcnt = 0;
        dly  = 0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_instr = '0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (rsp_en && imem_req_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = 0;
                    dly  = $urandom_range(min_dly, max_dly);
                end
                if (wcnt >= dly) begin
                    w = int'(imem_req_pc[15:12]);
                    imem_rsp_valid = 1'b1;
                    imem_rsp_instr = prog.exists(imem_req_pc) ? prog[imem_req_pc] : 32'd0;
                    fetch_log.push_back(w);
                    model_exec(w, imem_rsp_instr);
                    $display("fetch warp %0d pc %h instr %h", w, imem_req_pc, imem_rsp_instr);
                    busy = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin : done_mon
        int w;
        if (rst_n && done_valid) begin
            n_done++;
            check_eq("done_pending", exp_done.size() != 0, 1);
            if (exp_done.size() != 0) begin
                w = exp_done.pop_front();
                check_eq("done_warp_id", done_warp_id, w);
                check_eq("result_out", result_out, m_result(w));
                $display("done warp %0d result %h", done_warp_id, result_out);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int g, n, base_done;
        rst_n = 1'b0;
        kernel_valid = 1'b0;
        kernel_in = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_kernel_ready", kernel_ready, 1);
        check_eq("rst_imem_req_valid", imem_req_valid, 0);
        check_eq("rst_imem_req_pc", imem_req_pc, 0);
        check_eq("rst_init_req_valid", init_req_valid, 0);
        check_eq("rst_done_valid", done_valid, 0);
        check_eq("rst_result_out", result_out, 0);

        // Reset asserted while a fetch is outstanding.
        setup_kernel(9, 3, 1'b0);
        rsp_en = 1'b0;
        submit(9, 4);
        g = 0;
        while (!imem_req_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check_eq("fetch_before_reset", imem_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_imem_req_valid", imem_req_valid, 0);
        check_eq("midrst_done_valid", done_valid, 0);
        check_eq("midrst_init_req_valid", init_req_valid, 0);
        check_eq("midrst_kernel_ready", kernel_ready, 1);
        exp_done.delete();
        fetch_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_idle", imem_req_valid, 0);
        end

        // Warp 1: init timing, first fetch address, ADD result.
        setup_kernel(1, 0, 1'b1);
        prog[32'h1000] = 32'h8B020020;
        prog[32'h1004] = 32'h0;
        min_dly = 0;
        max_dly = 0;
        rsp_en  = 1'b1;
        submit(1, 4);
        @(negedge clk);
        check_eq("init_first_valid", init_req_valid, 1);
        check_eq("init_first_idx", init_reg_idx, 0);
        check_eq("init_warp_id", init_warp_id, 1);
        n = 1;
        while (init_req_valid && n < 64) begin
            @(negedge clk);
            if (init_req_valid) n++;
        end
        check_eq("init_cycles", n, 32);
        @(negedge clk);
        check_eq("first_fetch_valid", imem_req_valid, 1);
        check_eq("first_fetch_pc", imem_req_pc, 32'h1000);
        wait_dones(1, 200);

        // Warp 2 with two active lanes; the write to X31 must be discarded.
        setup_kernel(2, 0, 1'b1);
        prog[32'h2000] = 32'hAA0503E3;
        prog[32'h2004] = 32'h8B03007F;
        prog[32'h2008] = 32'h0;
        submit(2, 2);
        wait_dones(2, 300);

        // Two ready warps with a slow memory must be issued alternately.
        setup_kernel(1, 3, 1'b0);
        setup_kernel(2, 3, 1'b0);
        rsp_en = 1'b0;
        fetch_log.delete();
        submit(1, 4);
        submit(2, 3);
        repeat (80) @(negedge clk);
        min_dly = 3;
        max_dly = 3;
        rsp_en  = 1'b1;
        wait_dones(4, 400);
        for (int i = 0; i < 8; i++)
            check_eq("rr_order", (i < fetch_log.size()) ? fetch_log[i] : -1, (i % 2 == 0) ? 1 : 2);

        // Fill every slot, then watch kernel_ready return after the first completion.
        rsp_en  = 1'b0;
        min_dly = 0;
        max_dly = 0;
        for (int k = 0; k < NW; k++) setup_kernel(3 + k, $urandom_range(1, 4), 1'b0);
        for (int k = 0; k < NW; k++) submit(3 + k, $urandom_range(1, 4));
        @(negedge clk);
        check_eq("full_kernel_ready", kernel_ready, 0);
        rsp_en = 1'b1;
        g = 0;
        while (!done_valid && g < 400) begin
            @(negedge clk);
            g++;
        end
        check_eq("first_done_seen", done_valid, 1);
        check_eq("ready_during_done", kernel_ready, 0);
        @(negedge clk);
        check_eq("ready_after_done", kernel_ready, 1);
        wait_dones(4 + NW, 1000);

        // Random kernels with random thread counts, programs and memory latency.
        base_done = n_done;
        min_dly = 0;
        max_dly = 2;
        for (int k = 0; k < 6; k++) begin
            setup_kernel(7 + k, $urandom_range(2, 8), 1'b0);
            submit(7 + k, $urandom_range(0, TC));
        end
        wait_dones(base_done + 6, 5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
